// File: rtl/bicubic_pkg.sv
// rtl/bicubic_pkg.sv - shared tap count, column index type and {sign,mag} pixel helpers
package bicubic_pkg;

  localparam int TAP_N = 4;

  typedef logic [1:0] col_idx_t;

  // The sign bit sits directly above the magnitude field.
  function automatic int sign_idx(input int mag_w);
    return mag_w;
  endfunction

  // A zero magnitude is always stored as +0.
  function automatic logic norm_sign(input logic sign, input logic mag_nonzero);
    return sign & mag_nonzero;
  endfunction

endpackage

// File: rtl/bicubic_tile_bank.sv
// rtl/bicubic_tile_bank.sv - one 4x4 pixel bank with row write port, column read mux and full flag
module bicubic_tile_bank
  import bicubic_pkg::*;
#(
  parameter int MAG_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_wr_en,
  input  logic [1:0]                   i_wr_row,
  input  logic [TAP_N-1:0][MAG_W:0]    i_wr_pix,
  input  logic                         i_set_full,
  input  logic                         i_clr_full,
  input  col_idx_t                     i_rd_col,
  output logic [TAP_N-1:0][MAG_W:0]    o_rd_pix,
  output logic                         o_full
);

  logic [MAG_W:0] r_mem [TAP_N][TAP_N];
  logic           r_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < TAP_N; r++) begin
        for (int c = 0; c < TAP_N; c++) begin
          r_mem[r][c] <= '0;
        end
      end
      r_full <= 1'b0;
    end else begin
      if (i_wr_en) begin
        for (int c = 0; c < TAP_N; c++) begin
          r_mem[i_wr_row][c] <= i_wr_pix[c];
        end
      end
      // Set and clear never coincide: set needs the bank empty, clear needs it full.
      if (i_set_full) begin
        r_full <= 1'b1;
      end else if (i_clr_full) begin
        r_full <= 1'b0;
      end
    end
  end

  always_comb begin
    o_rd_pix = '0;
    for (int k = 0; k < TAP_N; k++) begin
      o_rd_pix[k] = r_mem[k][i_rd_col];
    end
  end

  assign o_full = r_full;

endmodule

// File: rtl/bicubic_row_transpose_buffer.sv
// rtl/bicubic_row_transpose_buffer.sv - double-banked 4x4 row-in / column-out transpose buffer
module bicubic_row_transpose_buffer
  import bicubic_pkg::*;
#(
  parameter int MAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W-1:0] in_mag1,
  input  logic [MAG_W-1:0] in_mag2,
  input  logic [MAG_W-1:0] in_mag3,
  input  logic [MAG_W-1:0] in_mag4,
  input  logic             in_sign1,
  input  logic             in_sign2,
  input  logic             in_sign3,
  input  logic             in_sign4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W:0]   out_p1,
  output logic [MAG_W:0]   out_p2,
  output logic [MAG_W:0]   out_p3,
  output logic [MAG_W:0]   out_p4,
  output logic [1:0]       out_col,
  output logic             out_last
);

  localparam int SIGN_IDX = sign_idx(MAG_W);

  logic [TAP_N-1:0][MAG_W-1:0] w_in_mag;
  logic [TAP_N-1:0]            w_in_sign;
  logic [TAP_N-1:0][MAG_W:0]   w_wr_pix;
  logic [TAP_N-1:0][MAG_W:0]   w_rd_pix [2];
  logic [1:0]                  w_full;
  logic                        w_wr_fire;
  logic                        w_rd_fire;
  logic                        w_wr_last;
  logic                        w_rd_last;

  logic                        r_wr_bank;
  logic [1:0]                  r_wr_row;
  logic                        r_rd_bank;
  col_idx_t                    r_rd_col;

  assign w_in_mag  = {in_mag4, in_mag3, in_mag2, in_mag1};
  assign w_in_sign = {in_sign4, in_sign3, in_sign2, in_sign1};

  always_comb begin
    w_wr_pix = '0;
    for (int c = 0; c < TAP_N; c++) begin
      w_wr_pix[c][MAG_W-1:0] = w_in_mag[c];
      w_wr_pix[c][SIGN_IDX]  = norm_sign(w_in_sign[c], |w_in_mag[c]);
    end
  end

  assign in_ready  = !w_full[r_wr_bank];
  assign out_valid = w_full[r_rd_bank];
  assign w_wr_fire = in_valid && in_ready;
  assign w_rd_fire = out_valid && out_ready;
  assign w_wr_last = (r_wr_row == 2'd3);
  assign w_rd_last = (r_rd_col == 2'd3);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic BANK = 1'(b);

    bicubic_tile_bank #(
      .MAG_W (MAG_W)
    ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .i_wr_en    (w_wr_fire && (r_wr_bank == BANK)),
      .i_wr_row   (r_wr_row),
      .i_wr_pix   (w_wr_pix),
      .i_set_full (w_wr_fire && w_wr_last && (r_wr_bank == BANK)),
      .i_clr_full (w_rd_fire && w_rd_last && (r_rd_bank == BANK)),
      .i_rd_col   (r_rd_col),
      .o_rd_pix   (w_rd_pix[b]),
      .o_full     (w_full[b])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_bank <= 1'b0;
      r_wr_row  <= 2'd0;
      r_rd_bank <= 1'b0;
      r_rd_col  <= 2'd0;
    end else begin
      if (w_wr_fire) begin
        r_wr_row <= r_wr_row + 2'd1;
        if (w_wr_last) begin
          r_wr_bank <= !r_wr_bank;
        end
      end
      if (w_rd_fire) begin
        r_rd_col <= r_rd_col + 2'd1;
        if (w_rd_last) begin
          r_rd_bank <= !r_rd_bank;
        end
      end
    end
  end

  assign out_p1   = w_rd_pix[r_rd_bank][0];
  assign out_p2   = w_rd_pix[r_rd_bank][1];
  assign out_p3   = w_rd_pix[r_rd_bank][2];
  assign out_p4   = w_rd_pix[r_rd_bank][3];
  assign out_col  = r_rd_col;
  assign out_last = w_rd_last;

endmodule

// File: tb/tb_bicubic_row_transpose_buffer.sv
// tb/tb_bicubic_row_transpose_buffer.sv - directed self-checking bench for the row transpose buffer
module tb_bicubic_row_transpose_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid, in_ready, out_valid, out_ready, out_last;
  logic [7:0] in_mag1, in_mag2, in_mag3, in_mag4;
  logic       in_sign1, in_sign2, in_sign3, in_sign4;
  logic [8:0] out_p1, out_p2, out_p3, out_p4;
  logic [1:0] out_col;

  int checks = 0;
  int errors = 0;

  logic [8:0] t2_p4 [4];

  bicubic_row_transpose_buffer #(.MAG_W(8)) dut (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_ready (in_ready),
    .in_mag1 (in_mag1), .in_mag2 (in_mag2), .in_mag3 (in_mag3), .in_mag4 (in_mag4),
    .in_sign1 (in_sign1), .in_sign2 (in_sign2), .in_sign3 (in_sign3), .in_sign4 (in_sign4),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_p1 (out_p1), .out_p2 (out_p2), .out_p3 (out_p3), .out_p4 (out_p4),
    .out_col (out_col), .out_last (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Row id -> magnitude 4*id+col, sign alternating with id and column.
  function automatic logic [7:0] mag_of(input int id, input int c);
    return 8'(4 * id + c);
  endfunction

  function automatic logic sign_of(input int id, input int c);
    return logic'((id + c) % 2);
  endfunction

  function automatic logic [8:0] pix(input int id, input int c);
    logic [7:0] m;
    m = mag_of(id, c);
    return {sign_of(id, c) && (m != 8'd0), m};
  endfunction

  task automatic set_row(input logic [7:0] m1, m2, m3, m4, input logic s1, s2, s3, s4);
    in_mag1 = m1; in_mag2 = m2; in_mag3 = m3; in_mag4 = m4;
    in_sign1 = s1; in_sign2 = s2; in_sign3 = s3; in_sign4 = s4;
  endtask

  task automatic set_id(input int id);
    set_row(mag_of(id, 0), mag_of(id, 1), mag_of(id, 2), mag_of(id, 3),
            sign_of(id, 0), sign_of(id, 1), sign_of(id, 2), sign_of(id, 3));
  endtask

  task automatic send_id(input int id);
    set_id(id);
    in_valid = 1'b1;
    chk($sformatf("send_rdy_id%0d", id), 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_col(input string tag, input int base, input int c);
    chk($sformatf("%s_valid_c%0d", tag, c), 32'(out_valid), 32'd1);
    chk($sformatf("%s_col_c%0d", tag, c), 32'(out_col), 32'(c));
    chk($sformatf("%s_last_c%0d", tag, c), 32'(out_last), 32'(c == 3));
    chk($sformatf("%s_p1_c%0d", tag, c), 32'(out_p1), 32'(pix(base + 0, c)));
    chk($sformatf("%s_p2_c%0d", tag, c), 32'(out_p2), 32'(pix(base + 1, c)));
    chk($sformatf("%s_p3_c%0d", tag, c), 32'(out_p3), 32'(pix(base + 2, c)));
    chk($sformatf("%s_p4_c%0d", tag, c), 32'(out_p4), 32'(pix(base + 3, c)));
  endtask

  initial begin
    int ec;
    logic rdy;
    logic [8:0] sv_p1, sv_p4;
    logic [1:0] sv_col;

    in_valid = 1'b0;
    out_ready = 1'b0;
    set_row(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_p1", 32'(out_p1), 32'd0);
    chk("rst_out_p4", 32'(out_p4), 32'd0);
    chk("rst_out_col", 32'(out_col), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Test 1: mag = 16*r + c, positive.
    out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      set_row(8'(16 * r + 0), 8'(16 * r + 1), 8'(16 * r + 2), 8'(16 * r + 3), 1'b0, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1;
      chk($sformatf("t1_ov_pre_r%0d", r), 32'(out_valid), 32'd0);
      chk($sformatf("t1_rdy_r%0d", r), 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("t1_valid_c%0d", c), 32'(out_valid), 32'd1);
      chk($sformatf("t1_col_c%0d", c), 32'(out_col), 32'(c));
      chk($sformatf("t1_last_c%0d", c), 32'(out_last), 32'(c == 3));
      chk($sformatf("t1_p1_c%0d", c), 32'(out_p1), 32'(c));
      chk($sformatf("t1_p2_c%0d", c), 32'(out_p2), 32'(16 + c));
      chk($sformatf("t1_p3_c%0d", c), 32'(out_p3), 32'(32 + c));
      chk($sformatf("t1_p4_c%0d", c), 32'(out_p4), 32'(48 + c));
      tick();
    end
    chk("t1_ov_post", 32'(out_valid), 32'd0);

    // Test 2: -0 normalisation and negative values.
    t2_p4[0] = 9'h000; t2_p4[1] = 9'h005; t2_p4[2] = 9'h000; t2_p4[3] = 9'h105;
    in_valid = 1'b1;
    set_row(8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1); tick();
    set_row(8'h05, 8'h05, 8'h05, 8'h05, 1'b1, 1'b1, 1'b1, 1'b1); tick();
    set_row(8'h7f, 8'h7f, 8'h7f, 8'h7f, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    set_row(8'h00, 8'h05, 8'h00, 8'h05, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("t2_valid_c%0d", c), 32'(out_valid), 32'd1);
      chk($sformatf("t2_p1_c%0d", c), 32'(out_p1), 32'h000);
      chk($sformatf("t2_p2_c%0d", c), 32'(out_p2), 32'h105);
      chk($sformatf("t2_p3_c%0d", c), 32'(out_p3), 32'h07f);
      chk($sformatf("t2_p4_c%0d", c), 32'(out_p4), 32'(t2_p4[c]));
      tick();
    end

    // Test 3: consumer stalled while 9 rows are offered.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_id(i);
      in_valid = 1'b1;
      chk($sformatf("t3_rdy_i%0d", i), 32'(in_ready), 32'd1);
      tick();
    end
    set_id(8);
    chk("t3_held_rdy0", 32'(in_ready), 32'd0);
    chk("t3_held_ov", 32'(out_valid), 32'd1);
    tick();
    tick();
    chk("t3_held_rdy1", 32'(in_ready), 32'd0);
    chk("t3_held_col", 32'(out_col), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k < 4) begin
        set_id(8);
        in_valid = 1'b1;
        chk($sformatf("t3_rdy_k%0d", k), 32'(in_ready), 32'd0);
      end else if (k < 8) begin
        set_id(8 + k - 4);
        in_valid = 1'b1;
        chk($sformatf("t3_rdy_k%0d", k), 32'(in_ready), 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      chk_col($sformatf("t3_k%0d", k), (k / 4) * 4, k % 4);
      tick();
    end
    in_valid = 1'b0;
    chk("t3_ov_post", 32'(out_valid), 32'd0);
    chk("t3_rdy_post", 32'(in_ready), 32'd1);

    // Test 4: continuous streaming of 16 rows.
    out_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (t < 16) begin
        set_id(12 + t);
        in_valid = 1'b1;
        chk($sformatf("t4_rdy_t%0d", t), 32'(in_ready), 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      if (t >= 4) begin
        chk_col($sformatf("t4_t%0d", t), 12 + ((t - 4) / 4) * 4, (t - 4) % 4);
      end else begin
        chk($sformatf("t4_ov_t%0d", t), 32'(out_valid), 32'd0);
      end
      tick();
    end
    in_valid = 1'b0;
    chk("t4_ov_post", 32'(out_valid), 32'd0);

    // Test 5: random back-pressure.
    for (int i = 0; i < 4; i++) send_id(28 + i);
    ec = 0;
    for (int n = 0; n < 60 && ec < 4; n++) begin
      out_ready = (n == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      chk_col($sformatf("t5_n%0d", n), 28, ec);
      rdy = out_ready;
      sv_p1 = out_p1; sv_p4 = out_p4; sv_col = out_col;
      tick();
      if (rdy) begin
        ec++;
      end else begin
        chk($sformatf("t5_stable_col_n%0d", n), 32'(out_col), 32'(sv_col));
        chk($sformatf("t5_stable_p1_n%0d", n), 32'(out_p1), 32'(sv_p1));
        chk($sformatf("t5_stable_p4_n%0d", n), 32'(out_p4), 32'(sv_p4));
      end
    end
    chk("t5_cols_drained", 32'(ec), 32'd4);
    out_ready = 1'b0;
    chk("t5_ov_post", 32'(out_valid), 32'd0);

    // Test 6: reset with a partial tile and a partly read full bank.
    for (int i = 0; i < 4; i++) send_id(32 + i);
    send_id(36);
    send_id(37);
    out_ready = 1'b1;
    chk_col("t6_pre", 32, 0);
    tick();
    out_ready = 1'b0;
    chk("t6_col1", 32'(out_col), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_ov", 32'(out_valid), 32'd0);
    chk("t6_rst_rdy", 32'(in_ready), 32'd1);
    chk("t6_rst_p1", 32'(out_p1), 32'd0);
    chk("t6_rst_p3", 32'(out_p3), 32'd0);
    chk("t6_rst_col", 32'(out_col), 32'd0);
    chk("t6_rst_last", 32'(out_last), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_id(40 + i);
    for (int c = 0; c < 4; c++) begin
      chk_col("t6_post", 40, c);
      tick();
    end
    chk("t6_ov_post", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
